// File: rtl/mux_pkg.sv
// Shared types and limits for the registered N:1 pipeline selector.
package mux_pkg;

  typedef enum logic [1:0] {
    EMPTY,
    BUSY,
    FULL
  } mux_state_t;

  localparam int MUX_MAX_IN = 16;

endpackage

// File: rtl/muxn_sel.sv
// Combinational N:1 selector; codes with no matching input produce all zeros.
module muxn_sel
  import mux_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int NUM_IN = 8
) (
  input  logic [NUM_IN*WIDTH-1:0]   in_data_i,
  input  logic [$clog2(NUM_IN)-1:0] sel_i,
  output logic [WIDTH-1:0]          data_o
);

  localparam int SEL_W = $clog2(NUM_IN);

  if (NUM_IN < 2 || NUM_IN > MUX_MAX_IN) begin : g_bad_num_in
    $error("muxn_sel: NUM_IN must lie in 2..MUX_MAX_IN");
  end

  always_comb begin
    // NOTE: default assigned first so every path drives data_o and no latch is inferred.
    data_o = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (sel_i == SEL_W'(i)) begin
        data_o = in_data_i[i*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: rtl/mux_pipe_stage.sv
// Registered N:1 selector with valid/ready handshake and a one-entry skid buffer.
// Optional sticky bad-select flag sel_err is built when MUX_SEL_CHK_EN is defined.
module mux_pipe_stage
  import mux_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int NUM_IN = 8,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready
`ifdef MUX_SEL_CHK_EN
  ,
  output logic                    sel_err
`endif
);

  mux_state_t       state_q;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic [WIDTH-1:0] sel_data;
  logic             accept;

  muxn_sel #(
    .WIDTH (WIDTH),
    .NUM_IN(NUM_IN)
  ) u_sel (
    .in_data_i(in_data),
    .sel_i    (sel),
    .data_o   (sel_data)
  );

  // Handshake outputs decode from the state register alone: no input-to-output path.
  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;
  assign accept    = in_valid & in_ready;

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: data registers are reset as well so out_data reads zero out of reset.
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else if (flush) begin
      state_q <= EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_q <= BUSY;
            main_q  <= sel_data;
          end
        end
        BUSY: begin
          if (accept && out_ready) begin
            main_q <= sel_data;
          end else if (accept) begin
            state_q <= FULL;
            skid_q  <= sel_data;
          end else if (out_ready) begin
            state_q <= EMPTY;
          end
        end
        FULL: begin
          if (out_ready) begin
            state_q <= BUSY;
            main_q  <= skid_q;
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

`ifdef MUX_SEL_CHK_EN
  logic sel_err_q;
  logic sel_oob;

  assign sel_oob = ({1'b0, sel} >= (SEL_W+1)'(NUM_IN));

  // Sticky until reset; a flush leaves it set.
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_err_q <= 1'b0;
    end else if (accept && sel_oob) begin
      sel_err_q <= 1'b1;
    end
  end

  assign sel_err = sel_err_q;
`endif

endmodule

// File: tb/tb_mux_pipe_stage.sv
// Self-checking bench for mux_pipe_stage: queue model plus directed literal checks.
// Exercises sel_err when MUX_SEL_CHK_EN is defined.
module tb_mux_pipe_stage;

  localparam int W = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1;
  logic flush = 1'b0;

  logic [W-1:0] vals [8];
  logic [8*W-1:0] in_data8;
  logic [6*W-1:0] in_data6;

  logic [2:0]   sel8      = 3'd1;
  logic         in_valid8 = 1'b1;
  logic         in_ready8;
  logic [W-1:0] out_data8;
  logic         out_valid8;
  logic         out_ready8 = 1'b1;

  logic [2:0]   sel6      = 3'd0;
  logic         in_valid6 = 1'b0;
  logic         in_ready6;
  logic [W-1:0] out_data6;
  logic         out_valid6;
  logic         out_ready6 = 1'b1;

`ifdef MUX_SEL_CHK_EN
  logic sel_err8;
  logic sel_err6;
`endif

  int checks   = 0;
  int failures = 0;

  initial begin
    vals[0] = 64'd10;
    vals[1] = 64'd100;
    vals[2] = 64'd64;
    vals[3] = 64'(-2418);
    vals[4] = 64'd10000;
    vals[5] = 64'd1;
    vals[6] = 64'd5;
    vals[7] = 64'd7;
    for (int i = 0; i < 8; i++) in_data8[i*W +: W] = vals[i];
    for (int i = 0; i < 6; i++) in_data6[i*W +: W] = vals[i];
  end

  mux_pipe_stage #(.WIDTH(W), .NUM_IN(8)) dut8 (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .in_data  (in_data8),
    .sel      (sel8),
    .in_valid (in_valid8),
    .in_ready (in_ready8),
    .out_data (out_data8),
    .out_valid(out_valid8),
    .out_ready(out_ready8)
`ifdef MUX_SEL_CHK_EN
    ,
    .sel_err  (sel_err8)
`endif
  );

  mux_pipe_stage #(.WIDTH(W), .NUM_IN(6)) dut6 (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .in_data  (in_data6),
    .sel      (sel6),
    .in_valid (in_valid6),
    .in_ready (in_ready6),
    .out_data (out_data6),
    .out_valid(out_valid6),
    .out_ready(out_ready6)
`ifdef MUX_SEL_CHK_EN
    ,
    .sel_err  (sel_err6)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model of dut8: an ordered queue holding at most two accepted values.
  logic [W-1:0] mq[$];
  bit           chk_on = 1'b0;
  bit           m_acc;

  always @(posedge clk) begin
    if (reset) begin
      mq.delete();
      chk_on = 1'b1;
    end else if (flush) begin
      mq.delete();
    end else begin
      m_acc = in_valid8 && (mq.size() < 2);
      if (mq.size() > 0 && out_ready8) void'(mq.pop_front());
      if (m_acc) mq.push_back(vals[sel8]);
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("cmp_in_ready", 64'(in_ready8), 64'(mq.size() < 2));
      check("cmp_out_valid", 64'(out_valid8), 64'(mq.size() > 0));
      if (mq.size() > 0) check("cmp_out_data", out_data8, mq[0]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    // 1. reset held two cycles with a pending offer on sel=1
    tick();
    check("rst1_valid", 64'(out_valid8), 64'd0);
    check("rst1_data", out_data8, 64'd0);
    tick();
    check("rst2_valid", 64'(out_valid8), 64'd0);
    check("rst2_data", out_data8, 64'd0);
    reset     = 1'b0;
    in_valid8 = 1'b0;
    tick();
    check("rel_in_ready", 64'(in_ready8), 64'd1);
    check("rel_valid", 64'(out_valid8), 64'd0);

    // 2. streaming with out_ready=1
    in_valid8 = 1'b1;
    sel8      = 3'd3;
    tick();
    check("sel3_data", out_data8, 64'hFFFF_FFFF_FFFF_F68E);
    check("sel3_valid", 64'(out_valid8), 64'd1);
    for (int i = 0; i < 8; i++) begin
      sel8 = 3'(i);
      tick();
      check("stream_valid", 64'(out_valid8), 64'd1);
      check("stream_data", out_data8, vals[i]);
    end
    in_valid8 = 1'b0;
    tick();
    check("stream_drain", 64'(out_valid8), 64'd0);

    // 3. back-pressure into FULL, then drain in order
    out_ready8 = 1'b0;
    in_valid8  = 1'b1;
    sel8       = 3'd1;
    tick();
    sel8 = 3'd2;
    tick();
    in_valid8 = 1'b0;
    check("full_in_ready", 64'(in_ready8), 64'd0);
    check("full_data", out_data8, 64'd100);
    tick();
    check("full_hold_data", out_data8, 64'd100);
    check("full_hold_ready", 64'(in_ready8), 64'd0);
    out_ready8 = 1'b1;
    tick();
    check("drain1_data", out_data8, 64'd64);
    check("drain1_valid", 64'(out_valid8), 64'd1);
    tick();
    check("drain2_valid", 64'(out_valid8), 64'd0);

    // 4. NUM_IN=6 instance: legal select, then out-of-range select
    in_valid6 = 1'b1;
    sel6      = 3'd5;
    tick();
    check("n6_sel5", out_data6, 64'd1);
    sel6 = 3'd7;
    tick();
    in_valid6 = 1'b0;
    check("n6_sel7_valid", 64'(out_valid6), 64'd1);
    check("n6_sel7_data", out_data6, 64'd0);
`ifdef MUX_SEL_CHK_EN
    check("n6_sel_err_set", 64'(sel_err6), 64'd1);
    check("n8_sel_err_clear", 64'(sel_err8), 64'd0);
`endif
    tick();

    // 5. flush in FULL with an offer present; flush in EMPTY with an accept
    out_ready8 = 1'b0;
    in_valid8  = 1'b1;
    sel8       = 3'd4;
    tick();
    sel8 = 3'd5;
    tick();
    check("f_full_ready", 64'(in_ready8), 64'd0);
    flush = 1'b1;
    sel8  = 3'd6;
    tick();
    flush      = 1'b0;
    in_valid8  = 1'b0;
    out_ready8 = 1'b1;
    check("flush_valid", 64'(out_valid8), 64'd0);
    check("flush_ready", 64'(in_ready8), 64'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("flush_quiet", 64'(out_valid8), 64'd0);
    end
    flush     = 1'b1;
    in_valid8 = 1'b1;
    sel8      = 3'd7;
    tick();
    flush     = 1'b0;
    in_valid8 = 1'b0;
    check("flush_acc_drop", 64'(out_valid8), 64'd0);
`ifdef MUX_SEL_CHK_EN
    check("sel_err_after_flush", 64'(sel_err6), 64'd1);
`endif

    // 6. reset while FULL
    out_ready8 = 1'b0;
    in_valid8  = 1'b1;
    sel8       = 3'd0;
    tick();
    sel8 = 3'd1;
    tick();
    in_valid8 = 1'b0;
    check("r_full_ready", 64'(in_ready8), 64'd0);
    reset = 1'b1;
    tick();
    check("rfull_valid", 64'(out_valid8), 64'd0);
    check("rfull_data", out_data8, 64'd0);
    check("rfull_ready", 64'(in_ready8), 64'd1);
    reset = 1'b0;
    tick();
    check("rfull_rel_ready", 64'(in_ready8), 64'd1);
    check("rfull_rel_valid", 64'(out_valid8), 64'd0);
`ifdef MUX_SEL_CHK_EN
    check("sel_err_reset", 64'(sel_err6), 64'd0);
`endif
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
